paralelo_serial_lanes: RTL and testbench

// Parametrised multi-lane serializer, successor to the single-lane 10-bit serializer.
// - Each lane sends one WIDTH-bit slice of an input word, one bit per clk.
// - Input words arrive on a valid/ready handshake into a one-entry holding buffer.
// - When no word is pending at a word boundary, the lanes send IDLE_WORD, e.g. a K28.5 comma, so the line never stalls.
// - Sits between the 8b/10b encoder and the line-side drivers.
//

---
 rtl/serdes_pkg.sv | 10 +
 rtl/ser_lane_shift.sv | 49 ++++
 rtl/paralelo_serial_lanes.sv | 119 +++++++++++
 tb/tb_paralelo_serial_lanes.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: constants shared by the serializer blocks.
//   K28_5_RDN / K28_5_RDP : the two running-disparity forms of the K28.5 comma
//   DEFAULT_WIDTH         : default lane word width (one 8b/10b symbol)
package serdes_pkg;

  localparam logic [9:0] K28_5_RDN     = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP     = 10'b1100000101;
  localparam int         DEFAULT_WIDTH = 10;

endpackage

// File: rtl/ser_lane_shift.sv
// ser_lane_shift: one serializer lane. Holds the WIDTH-bit word being sent,
// reloads it in parallel at a word boundary and selects the bit on the line.
//   clk, rst   : clock, synchronous active-high reset (reloads IDLE_WORD)
//   load       : parallel load strobe (already qualified with enable)
//   load_data  : next word for this lane
//   cnt        : shared bit counter, 0..WIDTH-1
//   bit_out    : bit of the current word selected by cnt
module ser_lane_shift
  import serdes_pkg::*;
#(
  parameter int              WIDTH     = DEFAULT_WIDTH,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5_RDN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_data,
  input  logic [$clog2(WIDTH)-1:0]   cnt,
  output logic                       bit_out
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] word_r;
  logic [CW-1:0]    idx_s;

  // Lane word register: idle comma after reset, new word at each load.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r <= IDLE_WORD;
    end else if (load) begin
      word_r <= load_data;
    end
  end

  // Bit select: the word is held still and the counter walks across it,
  // mirrored when the MSB goes out first.
  always_comb begin
    if (MSB_FIRST) begin
      idx_s = LAST_CNT - cnt;
    end else begin
      idx_s = cnt;
    end
    bit_out = word_r[idx_s];
  end

endmodule

// File: rtl/paralelo_serial_lanes.sv
// paralelo_serial_lanes: multi-lane serializer between the 8b/10b encoder
// and the line drivers. Words enter via valid/ready into a one-entry buffer;
// when nothing is pending at a word boundary every lane sends IDLE_WORD.
//   clk, rst   : clock, synchronous active-high reset
//   enb        : enable; low freezes all state and forces outputs to 0
//   in_valid   : in_data carries a word
//   in_data    : lane l slice is in_data[l*WIDTH +: WIDTH]
//   in_ready   : word accepted this cycle when in_valid is also high
//   ser_out    : one serial bit per lane
//   word_start : first bit of every word (data or idle)
//   idle_out   : current word is the idle filler
module paralelo_serial_lanes
  import serdes_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               LANES     = 1,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5_RDN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     in_ready,
  output logic [LANES-1:0]         ser_out,
  output logic                     word_start,
  output logic                     idle_out
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0]          cnt_r;
  logic [LANES*WIDTH-1:0] hold_data_r;
  logic                   hold_full_r;
  logic                   cur_idle_r;

  logic                   active_s;
  logic                   last_s;
  logic                   ready_s;
  logic                   xfer_s;
  logic                   load_s;
  logic [LANES*WIDTH-1:0] load_data_s;
  logic [LANES-1:0]       lane_bit_s;

  // Handshake and next-word selection. The held word always has priority
  // over a same-cycle transfer so words stay in order.
  always_comb begin
    active_s = enb & ~rst;
    last_s   = (cnt_r == LAST_CNT);
    ready_s  = ~hold_full_r | last_s;
    xfer_s   = active_s & in_valid & ready_s;
    load_s   = active_s & last_s;
    if (hold_full_r) begin
      load_data_s = hold_data_r;
    end else if (xfer_s) begin
      load_data_s = in_data;
    end else begin
      load_data_s = {LANES{IDLE_WORD}};
    end
  end

  // Bit counter, holding buffer and idle flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= '0;
      hold_data_r <= '0;
      hold_full_r <= 1'b0;
      cur_idle_r  <= 1'b1;
    end else if (enb) begin
      if (last_s) begin
        cnt_r <= '0;
        if (hold_full_r) begin
          // Held word goes out; a transfer now refills the buffer.
          cur_idle_r  <= 1'b0;
          hold_full_r <= xfer_s;
          if (xfer_s) begin
            hold_data_r <= in_data;
          end
        end else if (xfer_s) begin
          // Bypass straight into the lanes.
          cur_idle_r <= 1'b0;
        end else begin
          cur_idle_r <= 1'b1;
        end
      end else begin
        cnt_r <= cnt_r + CW'(1);
        if (xfer_s) begin
          hold_data_r <= in_data;
          hold_full_r <= 1'b1;
        end
      end
    end
  end

  // One lane register per slice, all sharing the counter and load strobe.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ser_lane_shift #(
      .WIDTH    (WIDTH),
      .MSB_FIRST(MSB_FIRST),
      .IDLE_WORD(IDLE_WORD)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .load_data(load_data_s[l*WIDTH +: WIDTH]),
      .cnt      (cnt_r),
      .bit_out  (lane_bit_s[l])
    );
  end

  // Outputs are quiet whenever the block is in reset or paused.
  assign in_ready   = active_s & ready_s;
  assign ser_out    = active_s ? lane_bit_s : {LANES{1'b0}};
  assign word_start = active_s & (cnt_r == '0);
  assign idle_out   = active_s & cur_idle_r;

endmodule

// File: tb/tb_paralelo_serial_lanes.sv
// Directed bench for paralelo_serial_lanes: a default single-lane instance
// and a 4-lane LSB-first instance sharing clock, reset and enable.
module tb_paralelo_serial_lanes;
  import serdes_pkg::*;

  localparam logic [9:0] IDLE = K28_5_RDN;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       v1;
  logic [9:0] d1;
  logic       rdy1, s1, ws1, id1;
  logic       v4;
  logic [39:0] d4;
  logic       rdy4, ws4, id4;
  logic [3:0] s4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  paralelo_serial_lanes dut1 (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(v1), .in_data(d1),
    .in_ready(rdy1), .ser_out(s1), .word_start(ws1), .idle_out(id1)
  );

  paralelo_serial_lanes #(.WIDTH(10), .LANES(4), .MSB_FIRST(1'b0)) dut4 (
    .clk(clk), .rst(rst), .enb(enb), .in_valid(v4), .in_data(d4),
    .in_ready(rdy4), .ser_out(s4), .word_start(ws4), .idle_out(id4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Check bits from..to of a single-lane MSB-first word, one per cycle.
  task automatic check_bits(input string tag, input logic [9:0] w, input logic idle,
                            input int from, input int to);
    for (int i = from; i <= to; i++) begin
      chk({tag, "_ser"},  32'(s1),  32'(w[9-i]));
      chk({tag, "_ws"},   32'(ws1), 32'(i == 0));
      chk({tag, "_idle"}, 32'(id1), 32'(idle));
      nxt();
    end
  endtask

  logic [9:0] lw [4];
  logic [9:0] lane1_seq;
  logic [3:0] exp4;

  initial begin
    rst = 1'b1; enb = 1'b1; v1 = 1'b0; d1 = 10'h000; v4 = 1'b0; d4 = 40'h0;
    nxt();
    nxt();
    // Reset: outputs forced low.
    chk("rst_ser",   32'(s1),   32'(1'b0));
    chk("rst_ws",    32'(ws1),  32'(1'b0));
    chk("rst_idle",  32'(id1),  32'(1'b0));
    chk("rst_ready", 32'(rdy1), 32'(1'b0));
    chk("rst_ser4",  32'(s4),   32'(4'h0));

    // Test 1: idle commas after reset release.
    rst = 1'b0;
    #1;
    chk("t1_ready", 32'(rdy1), 32'(1'b1));
    check_bits("t1_idle_a", IDLE, 1'b1, 0, 9);
    check_bits("t1_idle_b", IDLE, 1'b1, 0, 9);

    // Test 2: back-to-back words 2AA then 155.
    rst = 1'b1;
    nxt();
    rst = 1'b0; v1 = 1'b1; d1 = 10'h2AA;
    #1;
    chk("t2_ready0", 32'(rdy1), 32'(1'b1));
    chk("t2_ser0",   32'(s1),   32'(IDLE[9]));
    nxt();
    d1 = 10'h155;
    #1;
    for (int i = 1; i <= 9; i++) begin
      chk("t2_ready", 32'(rdy1), 32'(i == 9));
      chk("t2_ser_idle", 32'(s1), 32'(IDLE[9-i]));
      nxt();
    end
    v1 = 1'b0;
    #1;
    check_bits("t2_w2aa", 10'h2AA, 1'b0, 0, 9);
    check_bits("t2_w155", 10'h155, 1'b0, 0, 9);
    check_bits("t2_idle", IDLE,    1'b1, 0, 9);

    // Test 3: word 3FF accepted at cnt=3 waits in the buffer.
    nxt(); nxt(); nxt();
    v1 = 1'b1; d1 = 10'h3FF;
    #1;
    chk("t3_ready3", 32'(rdy1), 32'(1'b1));
    nxt();
    v1 = 1'b0;
    #1;
    for (int i = 4; i <= 8; i++) begin
      chk("t3_ready_held", 32'(rdy1), 32'(1'b0));
      nxt();
    end
    chk("t3_ready9", 32'(rdy1), 32'(1'b1));
    chk("t3_ser9",   32'(s1),   32'(IDLE[0]));
    nxt();
    check_bits("t3_w3ff", 10'h3FF, 1'b0, 0, 9);
    check_bits("t3_idle", IDLE,    1'b1, 0, 9);

    // Test 4: 5-cycle pause at cnt=4 of word 0F0.
    for (int i = 0; i < 9; i++) nxt();
    v1 = 1'b1; d1 = 10'h0F0;
    #1;
    chk("t4_ready9", 32'(rdy1), 32'(1'b1));
    nxt();
    v1 = 1'b0;
    #1;
    check_bits("t4_head", 10'h0F0, 1'b0, 0, 3);
    enb = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_pause_ser",   32'(s1),   32'(1'b0));
      chk("t4_pause_ws",    32'(ws1),  32'(1'b0));
      chk("t4_pause_idle",  32'(id1),  32'(1'b0));
      chk("t4_pause_ready", 32'(rdy1), 32'(1'b0));
      nxt();
    end
    enb = 1'b1;
    #1;
    check_bits("t4_tail", 10'h0F0, 1'b0, 4, 9);
    check_bits("t4_idle", IDLE,    1'b1, 0, 9);

    // Test 5: reset mid-idle-word while a word is held.
    nxt(); nxt();
    v1 = 1'b1; d1 = 10'h3FF;
    #1;
    nxt();
    v1 = 1'b0;
    #1;
    chk("t5_held", 32'(rdy1), 32'(1'b0));
    nxt(); nxt(); nxt();
    rst = 1'b1;
    #1;
    chk("t5_rst_ser",   32'(s1),   32'(1'b0));
    chk("t5_rst_ready", 32'(rdy1), 32'(1'b0));
    nxt();
    rst = 1'b0;
    #1;
    chk("t5_ready", 32'(rdy1), 32'(1'b1));
    check_bits("t5_idle_a", IDLE, 1'b1, 0, 9);
    check_bits("t5_idle_b", IDLE, 1'b1, 0, 9);

    // Test 6: four lanes, LSB first.
    lw[0] = 10'h3FF; lw[1] = 10'h00F; lw[2] = 10'h303; lw[3] = 10'h0FF;
    lane1_seq = 10'b1111000000;
    for (int i = 0; i < 9; i++) nxt();
    v4 = 1'b1; d4 = {lw[3], lw[2], lw[1], lw[0]};
    #1;
    chk("t6_ready9", 32'(rdy4), 32'(1'b1));
    nxt();
    v4 = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      exp4 = {lw[3][i], lw[2][i], lw[1][i], lw[0][i]};
      chk("t6_ser4",  32'(s4),    32'(exp4));
      chk("t6_lane0", 32'(s4[0]), 32'(1'b1));
      chk("t6_lane1", 32'(s4[1]), 32'(lane1_seq[9-i]));
      chk("t6_ws",    32'(ws4),   32'(i == 0));
      chk("t6_idle",  32'(id4),   32'(1'b0));
      nxt();
    end
    for (int i = 0; i < 10; i++) begin
      chk("t6_idle_ser", 32'(s4),  32'({4{IDLE[i]}}));
      chk("t6_idle_flag", 32'(id4), 32'(1'b1));
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
